// File: rtl/vec_assembler_pkg.sv
// ============================================================================
// Module : vec_assembler_pkg
// Brief  : Shared defaults and width helpers for the vector assembler slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vec_assembler_pkg;

  localparam int c_VECTOR_WIDTH  = 920;
  localparam int c_BUS_WIDTH     = 512;
  localparam int c_SUB_VECTOR_NO = 2;
  localparam int c_FIFO_DEPTH    = 4;

  function automatic int word_cntr_width(input int sub_no);
    return $clog2(sub_no) + 1;
  endfunction

  // Pair layout is {weight, vector}: the weight sits in the MSBs.
  function automatic int pair_width(input int vec_w, input int cnt_w);
    return vec_w + cnt_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vec_assembler_if.sv
// ============================================================================
// Module : vec_assembler_if
// Brief  : Valid/ready stream carrying {weight, vector} pairs downstream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface vec_assembler_if #(
  parameter int VECTOR_WIDTH = 920,
  parameter int CNT_WIDTH    = 10
);
  logic [VECTOR_WIDTH-1:0] o_Vector;
  logic [CNT_WIDTH-1:0]    o_Weight;
  logic                    o_Valid;
  logic                    i_Ready;

  modport master (output o_Vector, output o_Weight, output o_Valid, input  i_Ready);
  modport slave  (input  o_Vector, input  o_Weight, input  o_Valid, output i_Ready);
endinterface

`default_nettype wire

// File: rtl/vec_fifo.sv
// ============================================================================
// Module : vec_fifo
// Brief  : Synchronous first-word-fall-through FIFO with full/empty/level.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vec_fifo #(
  parameter int WIDTH = 930,
  parameter int DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rstn,
  input  wire logic                       i_push,
  input  wire logic [WIDTH-1:0]           i_data,
  input  wire logic                       i_pop,
  output logic      [WIDTH-1:0]           o_data,
  output logic                            o_full,
  output logic                            o_empty,
  output logic      [$clog2(DEPTH):0]     o_level
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_LW-1:0]  r_level;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_level == c_LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

  // A push into a full FIFO is accepted only when a pop frees the slot.
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  assign o_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + c_LW'(1);
        2'b01:   r_level <= r_level - c_LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/vec_assembler.sv
// ============================================================================
// Module : vec_assembler
// Brief  : Assembles popcount sub-vectors into fingerprints, pairs each with
//          its weight and buffers the pairs for the comparison stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vec_assembler
  import vec_assembler_pkg::*;
#(
  parameter int VECTOR_WIDTH  = c_VECTOR_WIDTH,
  parameter int BUS_WIDTH     = c_BUS_WIDTH,
  parameter int SUB_VECTOR_NO = c_SUB_VECTOR_NO,
  parameter int CNT_WIDTH     = $clog2(VECTOR_WIDTH),
  parameter int FIFO_DEPTH    = c_FIFO_DEPTH
) (
  input  wire logic                          clk,
  input  wire logic                          rstn,
  input  wire logic [BUS_WIDTH-1:0]          i_SubVector,
  input  wire logic                          i_Valid,
  input  wire logic [CNT_WIDTH-1:0]          i_Cnt,
  input  wire logic                          i_CntNew,
  vec_assembler_if.master                    dn,
  output logic      [$clog2(FIFO_DEPTH):0]   o_Level,
  output logic                               o_Overflow,
  output logic                               o_SyncErr
);

  localparam int c_WCW        = word_cntr_width(SUB_VECTOR_NO);
  localparam int c_PAIR_WIDTH = pair_width(VECTOR_WIDTH, CNT_WIDTH);
  localparam int c_WGT_LSB    = VECTOR_WIDTH;
  localparam int c_LW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_WCW-1:0] c_LAST_WORD = c_WCW'(SUB_VECTOR_NO - 1);

  logic [c_WCW-1:0]        r_word_cnt;
  logic [VECTOR_WIDTH-1:0] r_vec;
  logic [CNT_WIDTH-1:0]    r_wgt;
  logic                    r_vec_pend;
  logic                    r_wgt_pend;
  logic                    r_overflow;
  logic                    r_sync_err;

  logic                    w_last;
  logic [VECTOR_WIDTH-1:0] w_vec_next;
  logic                    w_pair;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic [c_LW-1:0]         w_level;
  logic [c_PAIR_WIDTH-1:0] w_head;

  assign w_last = i_Valid && (r_word_cnt == c_LAST_WORD);

  // Earlier words are held in per-word registers; the last word bypasses
  // straight into the completed vector. Bits beyond VECTOR_WIDTH are never stored.
  for (genvar j = 0; j < SUB_VECTOR_NO; j++) begin : g_word
    localparam int c_LO = j * BUS_WIDTH;
    localparam int c_W  = ((VECTOR_WIDTH - c_LO) < BUS_WIDTH) ? (VECTOR_WIDTH - c_LO) : BUS_WIDTH;
    if (j == SUB_VECTOR_NO - 1) begin : g_last
      assign w_vec_next[c_LO +: c_W] = i_SubVector[c_W-1:0];
    end else begin : g_body
      logic [c_W-1:0] r_word;
      always_ff @(posedge clk) begin
        if (i_Valid && (r_word_cnt == c_WCW'(j))) r_word <= i_SubVector[c_W-1:0];
      end
      assign w_vec_next[c_LO +: c_W] = r_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_word_cnt <= '0;
    end else if (i_Valid) begin
      r_word_cnt <= w_last ? '0 : r_word_cnt + c_WCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_last)   r_vec <= w_vec_next;
    if (i_CntNew) r_wgt <= i_Cnt;
  end

  assign w_pair = r_vec_pend && r_wgt_pend;
  assign w_pop  = !w_empty && dn.i_Ready;
  assign w_push = w_pair && (!w_full || w_pop);

  // A fresh arrival in the pairing cycle re-arms its flag rather than erroring.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_vec_pend <= 1'b0;
      r_wgt_pend <= 1'b0;
      r_overflow <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      if (w_last)      r_vec_pend <= 1'b1;
      else if (w_pair) r_vec_pend <= 1'b0;
      if (i_CntNew)    r_wgt_pend <= 1'b1;
      else if (w_pair) r_wgt_pend <= 1'b0;
      if (((w_last && r_vec_pend) || (i_CntNew && r_wgt_pend)) && !w_pair)
        r_sync_err <= 1'b1;
      if (w_pair && w_full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

  vec_fifo #(
    .WIDTH (c_PAIR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_data  ({r_wgt, r_vec}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Outputs are forced low while reset is held.
  assign dn.o_Vector = rstn ? w_head[VECTOR_WIDTH-1:0]        : '0;
  assign dn.o_Weight = rstn ? w_head[c_WGT_LSB +: CNT_WIDTH]  : '0;
  assign dn.o_Valid  = rstn && !w_empty;
  assign o_Level     = rstn ? w_level : '0;
  assign o_Overflow  = rstn && r_overflow;
  assign o_SyncErr   = rstn && r_sync_err;

endmodule

`default_nettype wire

// File: doc/vec_assembler.md
Name: vec_assembler

Overview:
- Sits directly downstream of the popcount stage (cnt1).
- Collects the SUB_VECTOR_NO bus-width sub-vectors of each fingerprint into one VECTOR_WIDTH vector and pairs it with the full weight that the popcount stage reports.
- Buffers the {weight, vector} pairs in a small FIFO and presents them to the comparison stage on a valid/ready handshake.
- The upstream stage has no backpressure; overflow is flagged, never stalled.

Parameters:
- VECTOR_WIDTH, 920, fingerprint width in bits.
- BUS_WIDTH, 512, width of one sub-vector word.
- SUB_VECTOR_NO, 2, words per fingerprint; SUB_VECTOR_NO*BUS_WIDTH >= VECTOR_WIDTH is required.
- CNT_WIDTH, $clog2(VECTOR_WIDTH), weight width.
- FIFO_DEPTH, 4, number of pair entries; must be a power of two >= 2.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- i_SubVector  in  BUS_WIDTH  sub-vector word from the popcount stage.
- i_Valid  in  1  i_SubVector is valid this cycle.
- i_Cnt  in  CNT_WIDTH  weight from the popcount stage.
- i_CntNew  in  1  i_Cnt holds the full weight of the most recently completed vector.
- o_Vector  out  VECTOR_WIDTH  assembled fingerprint at FIFO head.
- o_Weight  out  CNT_WIDTH  weight paired with o_Vector.
- o_Valid  out  1  FIFO head is valid.
- i_Ready  in  1  consumer accepts the head.
- o_Level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- o_Overflow  out  1  sticky: a pair was dropped because the FIFO was full.
- o_SyncErr  out  1  sticky: a weight or vector arrived while the previous one was still unpaired.

Behaviour:
- Reset: rstn is synchronous and active-low; clock is clk.
  - While rstn=0, all outputs are 0.
  - The word counter, both pending flags, the FIFO pointers and both sticky flags are cleared.
  - A reset in mid-operation discards any partial vector and all buffered pairs.
- Word assembly:
  - The word counter runs 0..SUB_VECTOR_NO-1 and advances on i_Valid.
  - Word j is written to assembly bits [j*BUS_WIDTH +: BUS_WIDTH]; bits at or above VECTOR_WIDTH are discarded.
  - The counter wraps to 0 after the last word.
  - Cycles without i_Valid hold the counter and the data.
- Vector completion:
  - When the last word is accepted, the full vector is latched into the pending-vector register and vec_pend is set.
  - If vec_pend is already set and not being paired in the same cycle, the older vector is overwritten and o_SyncErr is set.
- Weight capture:
  - On i_CntNew=1, i_Cnt is latched into the pending-weight register and wgt_pend is set.
  - If wgt_pend is already set and not being paired in the same cycle, the value is overwritten and o_SyncErr is set.
  - A weight may arrive before, with, or after its vector.
- Pairing:
  - In any cycle with vec_pend and wgt_pend both set, {weight, vector} is written to the FIFO and both flags clear.
  - A new vector or weight arriving in that same cycle sets its flag again; this is not an error.
  - If the FIFO is full and no pop happens that cycle, the pair is dropped, both flags clear, and o_Overflow is set.
- FIFO:
  - Registered, first-word-fall-through.
  - o_Valid = (level != 0).
  - Pop when o_Valid && i_Ready.
  - A push and pop in the same cycle while full is legal and leaves level unchanged.
  - A pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - o_Vector and o_Weight are undefined-but-stable when o_Valid=0; implement them as the RAM read of the head pointer.
- Latency:
  - Last word presented at edge E0 with the weight already pending: vec_pend is set after E0.
  - The FIFO write happens at E1, and o_Valid is high after E1, giving 2 cycles.
- Sticky flags clear only on reset.

Decomposition:
- Shared header vec_defs.vh holds:
  - the localparams WORD_CNTR_WIDTH = $clog2(SUB_VECTOR_NO)+1;
  - PAIR_WIDTH = CNT_WIDTH+VECTOR_WIDTH;
  - the pair field offsets (weight in the MSBs).
- One sub-module, vec_fifo: a parameterised synchronous FWFT FIFO with width PAIR_WIDTH and depth FIFO_DEPTH, providing full, empty and level.
- vec_assembler owns the word counter, assembly register, pending registers, pairing logic and sticky flags.

Test Plan:
1. Two words 0xAA..A then 0x55..5 with i_Valid, and i_CntNew with i_Cnt=460 one cycle after the last word:
   - o_Valid rises 2 cycles after i_CntNew.
   - o_Weight=460.
   - o_Vector[511:0]=0xAA..A and o_Vector[919:512]=0x55..5 truncated.
2. Weight pulse (i_Cnt=17) three cycles before its vector completes, with an idle gap between the words → single pair with weight 17, o_SyncErr=0.
3. i_Ready=0, push 5 complete pairs with FIFO_DEPTH=4:
   - o_Level=4 and the first 4 pairs are kept in order.
   - The 5th pair is dropped and o_Overflow=1.
4. FIFO full with i_Ready=1 while a new pair completes in the same cycle → level stays 4, no overflow, and the output order is preserved.
5. Two i_CntNew pulses (weights 10 then 20) before any vector completes → o_SyncErr=1, and the next pair carries weight 20.
6. rstn asserted after word 0 of a vector, then a full new vector plus weight sent → o_Level=0 during reset, o_Valid=0, and exactly one correct pair afterwards.
